// File: rtl/pe_window_sequencer.sv
// pe_window_sequencer: steps one fp16 MAC PE through a KERNELxKERNEL window and captures its result.
// Optional build macro PE_SEQ_RELU_EN clamps negative captured results (including -0.0) to zero.
module pe_window_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL      = 3,
    parameter int IMG_WIDTH   = 28,
    parameter int ADDR_WIDTH  = 10,
    parameter int WADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   busy,
    output logic [ADDR_WIDTH-1:0]  pix_addr,
    output logic [WADDR_WIDTH-1:0] wgt_addr,
    input  logic [DATA_WIDTH-1:0]  pix_data,
    input  logic [DATA_WIDTH-1:0]  wgt_data,
    output logic                   pe_reset,
    output logic [DATA_WIDTH-1:0]  pe_a,
    output logic [DATA_WIDTH-1:0]  pe_b,
    input  logic [DATA_WIDTH-1:0]  pe_result,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid
);
    localparam int NBEAT = KERNEL * KERNEL;
    localparam int CW = (KERNEL > 1) ? $clog2(KERNEL) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, CAPTURE} stateType;

    stateType state, nextState;
    logic [CW-1:0] col;
    logic [ADDR_WIDTH-1:0] rowBase;
    logic drainCnt;
    logic dataValid;
    logic lastBeat;
    logic [DATA_WIDTH-1:0] captured;

    // wgt_addr doubles as the beat counter since it always equals beat
    assign lastBeat = wgt_addr == WADDR_WIDTH'(NBEAT - 1);
    assign pe_reset = reset | (state == FETCH && wgt_addr == '0);

`ifdef PE_SEQ_RELU_EN
    assign captured = pe_result[DATA_WIDTH-1] ? '0 : pe_result;
`else
    assign captured = pe_result;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = start ? FETCH : IDLE;
            FETCH:   nextState = lastBeat ? DRAIN : FETCH;
            DRAIN:   nextState = drainCnt ? CAPTURE : DRAIN;
            CAPTURE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            pix_addr  <= '0;
            wgt_addr  <= '0;
            pe_a      <= '0;
            pe_b      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            col       <= '0;
            rowBase   <= '0;
            drainCnt  <= 1'b0;
            dataValid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            dataValid <= state == FETCH;
            pe_a      <= dataValid ? pix_data : '0;
            pe_b      <= dataValid ? wgt_data : '0;
            case (state)
                IDLE: if (start) begin
                    busy     <= 1'b1;
                    pix_addr <= base_addr;
                    rowBase  <= base_addr;
                    wgt_addr <= '0;
                    col      <= '0;
                    drainCnt <= 1'b0;
                end
                FETCH: if (!lastBeat) begin
                    wgt_addr <= wgt_addr + 1'b1;
                    col      <= (col == CW'(KERNEL - 1)) ? '0 : col + 1'b1;
                    rowBase  <= (col == CW'(KERNEL - 1)) ? rowBase + ADDR_WIDTH'(IMG_WIDTH) : rowBase;
                    pix_addr <= (col == CW'(KERNEL - 1)) ? rowBase + ADDR_WIDTH'(IMG_WIDTH) : pix_addr + 1'b1;
                end
                DRAIN: drainCnt <= 1'b1;
                CAPTURE: begin
                    out_data  <= captured;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_window_sequencer.sv
// tb_pe_window_sequencer: drives pe_window_sequencer with a buffer/PE model and checks against window sums.
module tb_pe_window_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [9:0] base_addr = '0;
    logic busy, pe_reset, out_valid;
    logic [9:0] pix_addr;
    logic [3:0] wgt_addr;
    logic [15:0] pix_data = '0, wgt_data = '0, pe_a, pe_b, pe_result, out_data;

    int checks = 0;
    int errors = 0;
    int pixInt [1024];
    int wgtInt [16];
    logic [15:0] pixMem [1024];
    logic [15:0] wgtMem [16];
    real accR = 0.0;
    logic prevOv = 1'b0;

    pe_window_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .busy(busy),
        .pix_addr(pix_addr), .wgt_addr(wgt_addr), .pix_data(pix_data), .wgt_data(wgt_data),
        .pe_reset(pe_reset), .pe_a(pe_a), .pe_b(pe_b), .pe_result(pe_result),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] r2h(input real x);
        real a;
        int e;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = x < 0.0;
        a = s ? -x : x;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        return {s, e[4:0], 10'($rtoi((a - 1.0) * 1024.0))};
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        int e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    // Registered buffers (data one cycle after address) and a free-running MAC PE
    always @(posedge clk) begin
        pix_data <= pixMem[pix_addr];
        wgt_data <= wgtMem[wgt_addr];
        accR <= pe_reset ? 0.0 : accR + h2r(pe_a) * h2r(pe_b);
    end
    always_comb pe_result = r2h(accR);

    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            assert (!prevOv) else begin errors++; $error("FAIL ov_double observed 1 expected 0"); end
        end
        prevOv <= out_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int pv, input int wv);
        for (int i = 0; i < 1024; i++) begin pixInt[i] = pv; pixMem[i] = r2h(real'(pv)); end
        for (int i = 0; i < 16; i++) begin wgtInt[i] = wv; wgtMem[i] = r2h(real'(wv)); end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 1024; i++) begin
            pixInt[i] = int'($urandom_range(6)) - 3;
            pixMem[i] = r2h(real'(pixInt[i]));
        end
        for (int i = 0; i < 16; i++) begin
            wgtInt[i] = int'($urandom_range(6)) - 3;
            wgtMem[i] = r2h(real'(wgtInt[i]));
        end
    endtask

    function automatic logic [15:0] expectWindow(input int base);
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += pixInt[(base + r * 28 + c) % 1024] * wgtInt[r * 3 + c];
`ifdef PE_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return r2h(real'(s));
    endfunction

    task automatic runWindow(input int base, input bit inject);
        int n;
        logic [15:0] exp;
        exp = expectWindow(base);
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'(base);
        @(negedge clk);
        start = 1'b0;
        base_addr = 10'(base + 300);
        for (int b = 0; b < 9; b++) begin
            if (b > 0) @(negedge clk);
            if (inject) start = b == 2;
            chk("pix_addr", 32'(pix_addr), 32'((base + (b / 3) * 28 + b % 3) % 1024));
            chk("wgt_addr", 32'(wgt_addr), 32'(b));
            chk("pe_reset", 32'(pe_reset), 32'(b == 0));
            chk("busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("latency", 32'(n), 32'd4);
        chk("out_data", 32'(out_data), 32'(exp));
        chk("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("ov_pulse", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n, gap, ovCount;
        fill(0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pix", 32'(pix_addr), 32'd0);
        chk("rst_wgt", 32'(wgt_addr), 32'd0);
        chk("rst_pe_a", 32'(pe_a), 32'd0);
        chk("rst_pe_b", 32'(pe_b), 32'd0);
        chk("rst_out", 32'(out_data), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_pe_reset", 32'(pe_reset), 32'd1);
        reset = 1'b0;

        fillRandom();
        runWindow(5, 1'b0);

        fill(1, 2);
        runWindow(5, 1'b0);
        chk("sum_18", 32'(out_data), 32'h4C80);

        fill(1, -1);
        runWindow(40, 1'b0);
`ifdef PE_SEQ_RELU_EN
        chk("neg_relu", 32'(out_data), 32'h0000);
`else
        chk("neg_sum", 32'(out_data), 32'hC880);
`endif

        // back-to-back with start held high
        fill(1, 1);
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'd0;
        @(negedge clk);
        base_addr = 10'd100;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 30);
        chk("b2b_first_ov", 32'(out_valid), 32'd1);
        chk("b2b_first", 32'(out_data), 32'h4880);
        @(negedge clk);
        start = 1'b0;
        gap = 1;
        while (!out_valid && gap < 30) begin @(negedge clk); gap++; end
        chk("b2b_gap", 32'(gap), 32'd13);
        chk("b2b_second", 32'(out_data), 32'h4880);

        // reset in the middle of a window
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_wgt", 32'(wgt_addr), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pix", 32'(pix_addr), 32'd0);
        chk("abort_wgt", 32'(wgt_addr), 32'd0);
        chk("abort_pe_a", 32'(pe_a), 32'd0);
        chk("abort_pe_reset", 32'(pe_reset), 32'd1);
        reset = 1'b0;
        ovCount = 0;
        repeat (20) begin @(negedge clk); ovCount += int'(out_valid); end
        chk("abort_no_ov", 32'(ovCount), 32'd0);
        runWindow(50, 1'b0);
        chk("after_abort", 32'(out_data), 32'h4880);

        fillRandom();
        runWindow(200, 1'b1);
        for (int k = 0; k < 6; k++) begin
            fillRandom();
            runWindow(k == 0 ? 1020 : int'($urandom_range(1023)), k[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
